// File: rtl/out_byte_buf_pkg.sv
// Shared types and defaults for the response output buffer.
// A byte-count field always holds (bytes - 1).
package out_byte_buf_pkg;

   localparam int DATA_W_DEF      = 256;
   localparam int CNT_W_DEF       = 4;
   localparam int ACK_TIMEOUT_DEF = 255;
   localparam int BYTE_W          = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_ACK  = 2'd2,
      ST_WAIT_DONE = 2'd3
   } bufState_t;

   function automatic int bytesFromCount(input int count);
      return count + 1;
   endfunction

   // Only the bytes a maximal count can reach are ever worth storing.
   function automatic int sendWidth(input int dataW, input int cntW);
      int full;
      full = BYTE_W * (1 << cntW);
      return (dataW < full) ? dataW : full;
   endfunction

endpackage

// File: rtl/out_byte_buf_if.sv
// Producer-side and transmitter-side signals of the output buffer.
interface out_byte_buf_if
   import out_byte_buf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
);

   logic [DATA_W-1:0] in_data;
   logic [CNT_W-1:0]  in_bytecount;
   logic              in_rdy;
   logic              out_buf_busy;
   logic [7:0]        tx_d;
   logic              tx_start;
   logic              tx_busy;
   logic              overrun;
   logic [7:0]        frames_sent;

   modport master (
      output in_data, in_bytecount, in_rdy, tx_busy,
      input  out_buf_busy, tx_d, tx_start, overrun, frames_sent
   );

   modport slave (
      input  in_data, in_bytecount, in_rdy, tx_busy,
      output out_buf_busy, tx_d, tx_start, overrun, frames_sent
   );

endinterface

// File: rtl/out_byte_buf_rise_detect.sv
// Registered 0->1 edge detector, shared by several pipeline stages.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic i_level,
   output logic o_rise
);

   logic r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= 1'b0;
      end else begin
         r_q <= i_level;
      end
   end

   assign o_rise = i_level & ~r_q;

endmodule

// File: rtl/out_byte_buf.sv
// Latches one response frame and feeds it, LSB byte first, to the UART
// transmitter, waiting for each byte's busy pulse before the next.
module out_byte_buf
   import out_byte_buf_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   out_byte_buf_if.slave bus
);

   localparam int SEND_W = sendWidth(DATA_W, CNT_W);
   localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

   bufState_t          r_state;
   logic [SEND_W-1:0]  r_data;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   r_idx;
   logic [ACK_W-1:0]   r_ackCnt;
   logic               r_busy;
   logic [7:0]         r_txD;
   logic               r_txStart;
   logic               r_overrun;
   logic [7:0]         r_frames;
   logic               w_post;
   logic [BYTE_W-1:0]  w_curByte;

   rise_detect u_rise (
      .clk     (clk),
      .rst     (rst),
      .i_level (bus.in_rdy),
      .o_rise  (w_post)
   );

   assign w_curByte = r_data[{r_idx, 3'b000} +: BYTE_W];

   generate
      if (DATA_W > SEND_W) begin : g_hiBits
         logic w_unusedHi;
         assign w_unusedHi = ^bus.in_data[DATA_W-1:SEND_W];
      end
   endgenerate

   // A post outside IDLE is dropped and flagged; the held frame carries on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_data    <= '0;
         r_count   <= '0;
         r_idx     <= '0;
         r_ackCnt  <= '0;
         r_busy    <= 1'b0;
         r_txD     <= '0;
         r_txStart <= 1'b0;
         r_overrun <= 1'b0;
         r_frames  <= '0;
      end else begin
         r_txStart <= 1'b0;
         if (w_post && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_post) begin
                  r_data  <= bus.in_data[SEND_W-1:0];
                  r_count <= bus.in_bytecount;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               r_txD     <= w_curByte;
               r_txStart <= 1'b1;
               r_ackCnt  <= '0;
               r_state   <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (bus.tx_busy) begin
                  r_state <= ST_WAIT_DONE;
               end else if (r_ackCnt == ACK_LAST) begin
                  r_overrun <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_ackCnt <= r_ackCnt + 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  if (r_idx == r_count) begin
                     r_frames <= r_frames + 8'd1;
                     r_busy   <= 1'b0;
                     r_state  <= ST_IDLE;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= ST_START;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.out_buf_busy = r_busy;
   assign bus.tx_d         = r_txD;
   assign bus.tx_start     = r_txStart;
   assign bus.overrun      = r_overrun;
   assign bus.frames_sent  = r_frames;

endmodule
